// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mul_div_unit
//
// Iterative multiply/divide unit for the MIPS datapath. Executes MULT, MULTU,
// DIV, DIVU (33-cycle latency, one bit per cycle) and MTHI/MTLO (single
// cycle) into private HI/LO registers.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : operation request, sampled only while idle
//   op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//            110/111 reserved (no effect)
//   srca   : rs operand (dividend / multiplicand / MTHI-MTLO data)
//   srcb   : rt operand (divisor / multiplier)
//   busy   : high while a multiply or divide is in flight
//   done   : one-cycle pulse after HI/LO are written by a multiply/divide
//   hi, lo : HI and LO registers
// ---------------------------------------------------------------------------
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Operation attributes captured at acceptance
   logic               r_is_div;
   logic               r_signed;
   logic               r_dbz;
   logic               r_neg_a;
   logic               r_neg_b;
   logic [WIDTH-1:0]   r_a;
   logic [CNT_W-1:0]   r_cnt;

   // Multiply datapath
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;

   // Divide datapath
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_divisor;

   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   // Acceptance-time decode
   logic               w_op_signed;
   logic               w_op_muldiv;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;

   // Iteration logic
   logic [2*WIDTH-1:0] w_acc_step;
   logic [WIDTH:0]     w_shifted;
   logic [WIDTH:0]     w_divisor_ext;
   logic               w_fits;
   logic [WIDTH:0]     w_rem_step;

   // Sign fix-up
   logic               w_neg_result;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign w_op_muldiv = (op[2] == 1'b0);

   // Two's-complement magnitudes; 0x80000000 negates to itself, which is the
   // correct unsigned magnitude, so no special case is required.
   assign w_mag_a = (w_op_signed && srca[WIDTH-1]) ? (~srca + 1'b1) : srca;
   assign w_mag_b = (w_op_signed && srcb[WIDTH-1]) ? (~srcb + 1'b1) : srcb;

   // Shift-add multiply: the multiplicand walks left while the multiplier
   // walks right, so bit 0 of the multiplier is always the current bit.
   assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   // Restoring divide: bring the next dividend bit into the partial remainder
   // and subtract the divisor only if it fits.
   assign w_shifted     = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
   assign w_divisor_ext = {1'b0, r_divisor};
   assign w_fits        = (w_shifted >= w_divisor_ext);
   assign w_rem_step    = w_fits ? (w_shifted - w_divisor_ext) : w_shifted;

   assign w_neg_result = r_signed && (r_neg_a ^ r_neg_b);
   assign w_prod_fix   = w_neg_result ? (~r_acc + 1'b1) : r_acc;
   assign w_quo_fix    = w_neg_result ? (~r_quo + 1'b1) : r_quo;
   // Remainder follows the sign of the dividend
   assign w_rem_fix    = (r_signed && r_neg_a) ? (~r_rem[WIDTH-1:0] + 1'b1)
                                               : r_rem[WIDTH-1:0];

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && w_op_muldiv) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            if (r_cnt == '0) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_div  <= 1'b0;
         r_signed  <= 1'b0;
         r_dbz     <= 1'b0;
         r_neg_a   <= 1'b0;
         r_neg_b   <= 1'b0;
         r_a       <= '0;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        // Both datapaths are loaded; only one is used.
                        r_is_div  <= op[1];
                        r_signed  <= w_op_signed;
                        r_dbz     <= (srcb == '0);
                        r_neg_a   <= srca[WIDTH-1];
                        r_neg_b   <= srcb[WIDTH-1];
                        r_a       <= srca;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_acc     <= '0;
                        r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier  <= w_mag_b;
                        r_rem     <= '0;
                        r_quo     <= w_mag_a;
                        r_divisor <= w_mag_b;
                     end
                     OP_MTHI: r_hi <= srca;
                     OP_MTLO: r_lo <= srca;
                     default: ;
                  endcase
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_is_div) begin
                  r_rem <= w_rem_step;
                  r_quo <= {r_quo[WIDTH-2:0], w_fits};
               end else begin
                  r_acc    <= w_acc_step;
                  r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
               end
            end
            S_FIX: begin
               r_done <= 1'b1;
               if (!r_is_div) begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end else if (r_dbz) begin
                  // Divide by zero returns all-ones quotient and the
                  // untouched dividend, regardless of signedness.
                  r_hi <= r_a;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
`timescale 1ns/1ps
module tb_mul_div_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] srca;
   logic [31:0] srcb;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_vec;
   int n_err;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .srca  (srca),
      .srcb  (srcb),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference ----------------
   // Result {hi,lo} of a mul/div computed with plain 64-bit arithmetic.
   function automatic logic [63:0] model_result(input logic [2:0] o,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'd0;
      case (o)
         3'd0: p = sa * sb;
         3'd1: p = {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) begin
               p = {a, 32'hFFFFFFFF};
            end else if (o == 3'd2) begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end else begin
               p = {a % b, a / b};
            end
         end
      endcase
      return p;
   endfunction

   // Model state: cycles left until the result lands (0 = idle).
   int          m_remain;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;
   logic        m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_remain <= 0;
         m_hi     <= 32'd0;
         m_lo     <= 32'd0;
         m_pend   <= 64'd0;
         m_done   <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_remain != 0) begin
            m_remain <= m_remain - 1;
            if (m_remain == 1) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_done <= 1'b1;
            end
         end else if (start) begin
            if (op <= 3'd3) begin
               m_pend   <= model_result(op, srca, srcb);
               m_remain <= 33;
            end else if (op == 3'd4) begin
               m_hi <= srca;
            end else if (op == 3'd5) begin
               m_lo <= srca;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic tick();
      @(negedge clk);
      n_vec++;
      if (busy !== (m_remain != 0) || done !== m_done || hi !== m_hi || lo !== m_lo) begin
         n_err++;
         $display("FAIL cycle_cmp t=%0t dut busy=%b done=%b hi=%h lo=%h / model busy=%b done=%b hi=%h lo=%h",
                  $time, busy, done, hi, lo, (m_remain != 0), m_done, m_hi, m_lo);
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one mul/div, return edges from acceptance to done and busy count.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      start = 1'b1; op = o; srca = a; srcb = b;
      tick();
      start = 1'b0; srca = $urandom; srcb = $urandom;
      bcnt = busy ? 1 : 0;
      lat  = 0;
      while (done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
         if (busy === 1'b1) bcnt++;
      end
      $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", o, a, b, hi, lo, lat);
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0; start = 1'b0; op = 3'd0; srca = 32'd0; srcb = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      rst_n = 1'b1;
      tick();

      // MULT -3 * 7
      run_op(3'd0, 32'hFFFFFFFD, 32'd7, lat, bcnt);
      chk("mult_latency", 64'(lat), 64'd33);
      chk("mult_busy_cycles", 64'(bcnt), 64'd33);
      chk("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
      chk("mult_lo", {32'd0, lo}, 64'hFFFFFFEB);

      // MULTU / MULT of all ones (back-to-back, issued in the done cycle)
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
      chk("multu_ones", {hi, lo}, 64'hFFFFFFFE_00000001);
      chk("multu_latency", 64'(lat), 64'd33);
      run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
      chk("mult_ones", {hi, lo}, 64'h00000000_00000001);

      // Divides
      run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, bcnt);
      chk("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op(3'd3, 32'd100, 32'd7, lat, bcnt);
      chk("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
      chk("divu_latency", 64'(lat), 64'd33);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
      chk("div_overflow", {hi, lo}, 64'h00000000_80000000);
      run_op(3'd3, 32'h00001234, 32'd0, lat, bcnt);
      chk("divu_by_zero", {hi, lo}, 64'h00001234_FFFFFFFF);
      chk("dbz_latency", 64'(lat), 64'd33);
      run_op(3'd2, 32'hFFFFFFF0, 32'd0, lat, bcnt);
      chk("div_by_zero", {hi, lo}, 64'hFFFFFFF0_FFFFFFFF);

      // Starts during a multiply must be ignored
      start = 1'b1; op = 3'd1; srca = 32'd1000; srcb = 32'd1000;
      tick();
      lat = 0;
      for (int k = 1; k < 40 && done !== 1'b1; k++) begin
         if (k == 5 || k == 20) begin
            start = 1'b1; op = 3'd4; srca = 32'h0000DEAD; srcb = 32'd9;
         end else if (k == 12) begin
            start = 1'b1; op = 3'd3; srca = 32'd55; srcb = 32'd3;
         end else begin
            start = 1'b0;
         end
         tick();
         lat++;
      end
      start = 1'b0;
      chk("ignored_latency", 64'(lat), 64'd33);
      chk("ignored_result", {hi, lo}, 64'h00000000_000F4240);
      $display("op=1 a=000003e8 b=000003e8 with ignored starts -> hi=%h lo=%h", hi, lo);

      // MTHI in idle
      start = 1'b1; op = 3'd4; srca = 32'h0000DEAD;
      tick();
      start = 1'b0;
      chk("mthi_hi", {32'd0, hi}, 64'h0000DEAD);
      chk("mthi_busy", {63'd0, busy}, 64'd0);
      chk("mthi_done", {63'd0, done}, 64'd0);
      $display("MTHI 0000dead -> hi=%h busy=%b done=%b", hi, busy, done);
      start = 1'b1; op = 3'd5; srca = 32'h0000BEEF;
      tick();
      start = 1'b0;
      chk("mtlo_lo", {32'd0, lo}, 64'h0000BEEF);
      start = 1'b1; op = 3'd6; srca = 32'h12345678;
      tick();
      start = 1'b0;
      chk("reserved_noop", {hi, lo}, 64'h0000DEAD_0000BEEF);

      // Reset in the middle of a divide
      start = 1'b1; op = 3'd2; srca = 32'd1000; srcb = 32'd7;
      tick();
      start = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_done", {63'd0, done}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      $display("reset mid-DIV -> busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      run_op(3'd1, 32'd3, 32'd5, lat, bcnt);
      chk("post_rst_multu", {hi, lo}, 64'd15);
      chk("post_rst_latency", 64'(lat), 64'd33);

      // Randomised traffic, including starts while busy and reserved ops
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 3) == 0);
         op    = 3'($urandom_range(0, 7));
         srca  = rand_operand();
         srcb  = rand_operand();
         tick();
         if (done === 1'b1) $display("random result: hi=%h lo=%h", hi, lo);
      end
      start = 1'b0;
      repeat (40) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
